// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code to calculator-key decoder.
package ps2_kbd_pkg;

    localparam int KEY_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_e;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_ERR = 8'h00;

    localparam logic [KEY_W-1:0] KEY_0     = 5'd0;
    localparam logic [KEY_W-1:0] KEY_1     = 5'd1;
    localparam logic [KEY_W-1:0] KEY_2     = 5'd2;
    localparam logic [KEY_W-1:0] KEY_3     = 5'd3;
    localparam logic [KEY_W-1:0] KEY_4     = 5'd4;
    localparam logic [KEY_W-1:0] KEY_5     = 5'd5;
    localparam logic [KEY_W-1:0] KEY_6     = 5'd6;
    localparam logic [KEY_W-1:0] KEY_7     = 5'd7;
    localparam logic [KEY_W-1:0] KEY_8     = 5'd8;
    localparam logic [KEY_W-1:0] KEY_9     = 5'd9;
    localparam logic [KEY_W-1:0] KEY_ADD   = 5'd10;
    localparam logic [KEY_W-1:0] KEY_SUB   = 5'd11;
    localparam logic [KEY_W-1:0] KEY_MUL   = 5'd12;
    localparam logic [KEY_W-1:0] KEY_DIV   = 5'd13;
    localparam logic [KEY_W-1:0] KEY_ENTER = 5'd14;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 5'd15;
    localparam logic [KEY_W-1:0] KEY_BKSP  = 5'd16;

endpackage

// File: rtl/ps2_scan_lut.sv
// Combinational Set-2 map from {extended, scan byte} to calculator key code.
module ps2_scan_lut
    import ps2_kbd_pkg::*;
(
    input  logic             i_ext,
    input  logic [7:0]       i_code,
    output logic             o_hit,
    output logic [KEY_W-1:0] o_key
);

    always_comb begin
        o_hit = 1'b1;
        o_key = KEY_0;
        case ({i_ext, i_code})
            9'h045, 9'h070: o_key = KEY_0;
            9'h016, 9'h069: o_key = KEY_1;
            9'h01E, 9'h072: o_key = KEY_2;
            9'h026, 9'h07A: o_key = KEY_3;
            9'h025, 9'h06B: o_key = KEY_4;
            9'h02E, 9'h073: o_key = KEY_5;
            9'h036, 9'h074: o_key = KEY_6;
            9'h03D, 9'h06C: o_key = KEY_7;
            9'h03E, 9'h075: o_key = KEY_8;
            9'h046, 9'h07D: o_key = KEY_9;
            9'h079:         o_key = KEY_ADD;
            9'h07B, 9'h04E: o_key = KEY_SUB;
            9'h07C:         o_key = KEY_MUL;
            9'h14A:         o_key = KEY_DIV;
            9'h05A, 9'h15A, 9'h055: o_key = KEY_ENTER;
            9'h076:         o_key = KEY_CLEAR;
            9'h066:         o_key = KEY_BKSP;
            default: begin
                o_hit = 1'b0;
                o_key = KEY_0;
            end
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 scan-code bytes into one-cycle calculator key events: prefix
// resolution, typematic suppression and a timeout on dangling prefixes.
module ps2_key_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TMO_W          = 18
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_done_i,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid_o,
    output logic             prefix_pending_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             r_sync1, r_sync2, r_edge;
    state_e           r_state;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_held_v, r_held_ext;
    logic [7:0]       r_held_code;

    logic             w_byte_evt, w_ext, w_held_match, w_hit;
    logic [KEY_W-1:0] w_key;

    // Flops preset high so a flag already high at reset release is not a fall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_edge  <= 1'b1;
        end else begin
            r_sync1 <= rx_done_i;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    assign w_byte_evt   = r_edge && !r_sync2 && (rx_data_i != SC_ERR);
    assign w_ext        = (r_state == EXT) || (r_state == EXT_BRK);
    assign w_held_match = r_held_v && (r_held_ext == w_ext) && (r_held_code == rx_data_i);

    ps2_scan_lut u_lut (
        .i_ext  (w_ext),
        .i_code (rx_data_i),
        .o_hit  (w_hit),
        .o_key  (w_key)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state          <= IDLE;
            r_tmo_cnt        <= '0;
            r_held_v         <= 1'b0;
            r_held_ext       <= 1'b0;
            r_held_code      <= 8'h00;
            key_o            <= KEY_0;
            key_valid_o      <= 1'b0;
            prefix_pending_o <= 1'b0;
        end else begin
            key_valid_o <= 1'b0;
            if (w_byte_evt) begin
                r_tmo_cnt <= '0;
                if ((r_state == IDLE || r_state == EXT) && rx_data_i == SC_EXT) begin
                    r_state          <= EXT;
                    prefix_pending_o <= 1'b1;
                end else if (r_state == IDLE && rx_data_i == SC_BRK) begin
                    r_state          <= BRK;
                    prefix_pending_o <= 1'b1;
                end else if (r_state == EXT && rx_data_i == SC_BRK) begin
                    r_state          <= EXT_BRK;
                    prefix_pending_o <= 1'b1;
                end else begin
                    // Any other byte completes a make or break and ends the sequence.
                    r_state          <= IDLE;
                    prefix_pending_o <= 1'b0;
                    if (r_state == BRK || r_state == EXT_BRK) begin
                        if (w_held_match) begin
                            r_held_v <= 1'b0;
                        end
                    end else if (w_hit && !w_held_match) begin
                        key_valid_o <= 1'b1;
                        key_o       <= w_key;
                        r_held_v    <= 1'b1;
                        r_held_ext  <= w_ext;
                        r_held_code <= rx_data_i;
                    end
                end
            end else if (r_state != IDLE) begin
                if (r_tmo_cnt == TMO_LAST) begin
                    r_state          <= IDLE;
                    r_tmo_cnt        <= '0;
                    prefix_pending_o <= 1'b0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: directed scenarios plus random byte streams against a key-level model.
module tb_ps2_key_decoder;

    localparam int T = 64;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_done_i = 1'b1;
    logic [4:0] key_o;
    logic       key_valid_o;
    logic       prefix_pending_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(T), .TMO_W(7)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .rx_data_i        (rx_data_i),
        .rx_done_i        (rx_done_i),
        .key_o            (key_o),
        .key_valid_o      (key_valid_o),
        .prefix_pending_o (prefix_pending_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: key table keyed by ext*256+byte, plus pending-prefix flags and held key.
    int   lut[int];
    bit   m_ext, m_brk, m_hv, m_hext;
    byte  m_hb;
    int   m_last;

    task automatic init_lut();
        int main_row[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
        int keypad[10]   = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};
        for (int i = 0; i < 10; i++) begin
            lut[main_row[i]] = i;
            lut[keypad[i]]   = i;
        end
        lut['h79] = 10; lut['h7B] = 11; lut['h4E] = 11; lut['h7C] = 12;
        lut[256 + 'h4A] = 13;
        lut['h5A] = 14; lut[256 + 'h5A] = 14; lut['h55] = 14;
        lut['h76] = 15; lut['h66] = 16;
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_hv = 0; m_hext = 0; m_hb = 0; m_last = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input int evt,
                              output bit ev, output int k, output bit pend);
        int idx;
        ev = 0;
        k  = 0;
        if (b != 8'h00) begin
            if ((m_ext || m_brk) && (evt - m_last > T)) begin
                m_ext = 0;
                m_brk = 0;
            end
            m_last = evt;
            if (m_brk) begin
                if (m_hv && m_hext == m_ext && m_hb == b) m_hv = 0;
                m_ext = 0;
                m_brk = 0;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else begin
                idx = (m_ext ? 256 : 0) + int'(b);
                if (lut.exists(idx) && !(m_hv && m_hext == m_ext && m_hb == b)) begin
                    ev     = 1;
                    k      = lut[idx];
                    m_hv   = 1;
                    m_hext = m_ext;
                    m_hb   = b;
                end
                m_ext = 0;
            end
        end
        pend = m_ext || m_brk;
    endtask

    // Drives one frame at a falling edge; the pulse must land on the third sample.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit         ev, pend;
        int         k;
        logic [7:0] pat;
        logic [4:0] got_k;
        logic       got_p;
        @(negedge clk_i);
        rx_data_i = b;
        rx_done_i = 1'b0;
        model_byte(b, cyc + 3, ev, k, pend);
        pat   = 8'h00;
        got_k = 5'd0;
        got_p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            pat[i] = key_valid_o;
            if (key_valid_o) got_k = key_o;
            if (i == 2) got_p = prefix_pending_o;
        end
        chk($sformatf("evt_timing[%02h]", b), pat, ev ? 8'h04 : 8'h00);
        if (ev) chk($sformatf("key[%02h]", b), got_k, k);
        chk($sformatf("pending[%02h]", b), got_p, pend);
        rx_done_i = 1'b1;
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i], 3);
    endtask

    logic [7:0] pool[$] = '{8'h45, 8'h16, 8'h1E, 8'h2E, 8'h70, 8'h79, 8'h7B, 8'h4E,
                            8'h7C, 8'h4A, 8'h5A, 8'h55, 8'h76, 8'h66, 8'h7D, 8'h1C};

    initial begin
        bit         ev, pend;
        int         k, nev;
        logic [7:0] b, last_b;

        init_lut();
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_key", key_o, 0);
        chk("rst_valid", key_valid_o, 0);
        chk("rst_pending", prefix_pending_o, 0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        send_seq('{8'h16, 8'hF0, 8'h16, 8'h16, 8'hF0, 8'h16});
        send_seq('{8'h79, 8'h79, 8'h79, 8'hF0, 8'h79, 8'h79, 8'hF0, 8'h79});
        send_seq('{8'hE0, 8'h4A, 8'hE0, 8'hF0, 8'h4A, 8'h4A});
        send_seq('{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'h5A, 8'hF0, 8'h5A});

        // Dangling E0 must expire after exactly T cycles with no event.
        @(negedge clk_i);
        rx_data_i = 8'hE0;
        rx_done_i = 1'b0;
        model_byte(8'hE0, cyc + 3, ev, k, pend);
        nev = 0;
        for (int i = 0; i < T + 5; i++) begin
            @(negedge clk_i);
            if (i == 5) rx_done_i = 1'b1;
            if (key_valid_o) nev++;
            if (i == T + 1) chk("tmo_still_pending", prefix_pending_o, 1);
            if (i == T + 2) chk("tmo_expired", prefix_pending_o, 0);
        end
        chk("tmo_no_event", nev, 0);
        send_byte(8'h45, 3);

        // Break byte lands on the very cycle the F0 would expire.
        send_byte(8'hF0, T - 9);
        send_byte(8'h45, 3);
        send_byte(8'h45, 3);
        send_seq('{8'hF0, 8'h45});

        // Reset while in the extended-break state with 2E held.
        send_seq('{8'h2E, 8'hE0, 8'hF0});
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_key", key_o, 0);
        chk("midrst_valid", key_valid_o, 0);
        chk("midrst_pending", prefix_pending_o, 0);
        rst_i = 1'b0;
        model_reset();
        repeat (4) @(negedge clk_i);
        send_byte(8'h00, 3);
        send_byte(8'h2E, 3);

        last_b = 8'h45;
        for (int n = 0; n < 250; n++) begin
            int r, gap;
            r = int'($urandom_range(0, 99));
            if (r < 14)      b = 8'hE0;
            else if (r < 32) b = 8'hF0;
            else if (r < 36) b = 8'h00;
            else if (r < 56) b = last_b;
            else             b = pool[$urandom_range(0, pool.size() - 1)];
            if (b != 8'hE0 && b != 8'hF0 && b != 8'h00) last_b = b;
            gap = ($urandom_range(0, 19) == 0) ? (T - 10 + int'($urandom_range(0, 2)))
                                               : int'($urandom_range(1, 6));
            send_byte(b, gap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
